byte_serial_alu_sequencer: RTL and testbench
============================================

Name: byte_serial_alu_sequencer

Overview:
- Performs 32-bit ADD/SUB/AND/OR/XOR by reusing one bit8_look_ahead_carry_adder slice over NUM_BYTES consecutive cycles, least significant byte first.
- The carry is chained between bytes through a register.
- This is the area-reduced ALU path for the multi-cycle MIPS32 core: it sits between the decode/issue stage and writeback.
- Valid/ready handshake on both the request side and the result side.

Parameters:
NUM_BYTES, 4, number of byte slices; data width W = 8*NUM_BYTES.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request.
op_in  input  3  operation code (see package).
A_in  input  W  operand A.
B_in  input  W  operand B.
out_valid  output  1  result valid; held until accepted.
out_ready  input  1  consumer accepts result.
R_out  output  W  result.
C_out  output  1  carry out (SUB: 1 = no borrow).
V_out  output  1  signed overflow.
Z_out  output  1  result == 0.
N_out  output  1  result MSB.
busy_out  output  1  state != IDLE.

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset rst is synchronous and active-high.
- FSM states: IDLE, RUN, DONE.
- Reset:
  - State goes to IDLE.
  - R_out, C_out, V_out, Z_out, N_out, out_valid, busy_out all become 0.
  - Byte index and carry register become 0.
  - in_ready = (state == IDLE) && !rst.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch A_in and op_in. Latch B_in, or ~B_in when op = SUB.
  - Carry register is loaded with 1 for SUB, 0 otherwise. Index is set to 0. Go to RUN.
- RUN:
  - The slice is driven with A[8*idx+:8], B'[8*idx+:8] and the carry register.
  - Each cycle, result byte idx is captured from the slice output selected by op:
    - S_out for ADD/SUB.
    - AND_out, OR_out or XOR_out for the logic ops.
  - Carry register <= slice C_out. idx increments.
  - The capture at idx = NUM_BYTES-1 transitions the FSM to DONE.
- Latency: out_valid rises exactly NUM_BYTES cycles after the accepting edge (4 by default).
- DONE:
  - out_valid = 1. R_out and the flags are stable and registered.
  - On out_ready: out_valid drops and the FSM returns to IDLE.
  - Throughput is at best one operation per NUM_BYTES+2 cycles.
- Flags:
  - C_out = final slice carry for ADD/SUB; 0 for logic ops.
  - V_out = (A[W-1] == B'[W-1]) && (R[W-1] != A[W-1]) for ADD/SUB; 0 for logic ops.
  - Z_out and N_out are valid for all ops.
- Backpressure: out_valid and the result are held indefinitely while out_ready = 0. in_valid is ignored (in_ready = 0) in RUN and DONE.
- Reserved opcodes are executed as ADD. No error indication.
- Reset mid-RUN or mid-DONE: the operation is discarded with no result, and the reset values above apply on the next edge.
- Wrap-around: the ADD result is modulo 2^W; the carry appears only on C_out.
- Inputs that change while busy have no effect, since operands are latched at accept.

Decomposition:
- Shared package alu_pkg holds:
  - op codes: OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3, OP_XOR = 3'd4;
  - FSM state encodings: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - constant SLICE_W = 8.
- Sub-module: one instance of the existing bit8_look_ahead_carry_adder as the byte slice. All other logic (FSM, operand/result registers, byte mux/demux, flags) is inline.

Test Plan:
- ADD: A = 0x00000094, B = 0x00000035 -> R = 0x000000C9, C = 0, V = 0, Z = 0; out_valid 4 cycles after accept.
- Cross-byte carry and wrap:
  - ADD 0x000000FF + 0x00000001 -> 0x00000100.
  - ADD 0xFFFFFFFF + 0x00000001 -> 0x00000000, C = 1, Z = 1.
- SUB and overflow:
  - SUB 5 - 7 -> 0xFFFFFFFE, C = 0, N = 1, V = 0.
  - ADD 0x7FFFFFFF + 1 -> 0x80000000, V = 1, C = 0.
  - SUB 0x80000000 - 1 -> 0x7FFFFFFF, V = 1, C = 1.
- Logic ops with A = 0x94943535, B = 0x35359494:
  - AND -> 0x14141414;
  - OR -> 0xB5B5B5B5;
  - XOR -> 0xA1A1A1A1;
  - C = V = 0 for all three.
- Backpressure and busy:
  - Hold out_ready = 0 for 3 cycles: the result stays stable.
  - in_valid with new operands during RUN/DONE is not accepted.
  - After out_ready, in_ready = 1 on the next cycle.
- Reset: assert rst during the second RUN cycle -> next edge gives IDLE, out_valid = 0, R_out = 0. A new ADD afterwards completes correctly with no carry leakage.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the byte-serial ALU sequencer.
//   SLICE_W : width of the reused adder slice (one byte)
//   op_e    : operation codes carried on op_in (reserved codes execute as ADD)
//   state_e : sequencer FSM encodings
package alu_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/byte_serial_alu_sequencer_if.sv
// Request/result bundle of the byte-serial ALU.
//   master : issue side (drives request, consumes result)
//   slave  : the ALU sequencer
// Request : in_valid/in_ready handshake with op_in, A_in, B_in.
// Result  : out_valid/out_ready handshake with R_out and C/V/Z/N flags.
// busy_out reports that the sequencer is not idle.
interface byte_serial_alu_sequencer_if
  import alu_pkg::*;
#(
  parameter int NUM_BYTES = 4
);
  localparam int W = SLICE_W * NUM_BYTES;

  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op_in;
  logic [W-1:0] A_in;
  logic [W-1:0] B_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] R_out;
  logic         C_out;
  logic         V_out;
  logic         Z_out;
  logic         N_out;
  logic         busy_out;

  modport master (
    output in_valid, op_in, A_in, B_in, out_ready,
    input  in_ready, out_valid, R_out, C_out, V_out, Z_out, N_out, busy_out
  );

  modport slave (
    input  in_valid, op_in, A_in, B_in, out_ready,
    output in_ready, out_valid, R_out, C_out, V_out, Z_out, N_out, busy_out
  );

endinterface

// File: rtl/bit8_look_ahead_carry_adder.sv
// One byte slice: carry-lookahead adder plus bitwise AND/OR/XOR outputs.
//   A_in, B_in : byte operands
//   C_in       : carry into bit 0
//   S_out      : A + B + C_in (low byte)
//   C_out      : carry out of bit 7
//   AND_out, OR_out, XOR_out : bitwise results
module bit8_look_ahead_carry_adder
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] A_in,
  input  logic [SLICE_W-1:0] B_in,
  input  logic               C_in,
  output logic [SLICE_W-1:0] S_out,
  output logic               C_out,
  output logic [SLICE_W-1:0] AND_out,
  output logic [SLICE_W-1:0] OR_out,
  output logic [SLICE_W-1:0] XOR_out
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign g = A_in & B_in;
  assign p = A_in ^ B_in;

  // Each carry is a flat sum of generate terms gated by the propagate chain
  // below it, so no carry depends on a lower computed carry.
  always_comb begin
    logic run_p;
    run_p = 1'b0;
    c     = '0;
    c[0]  = C_in;
    for (int i = 0; i < SLICE_W; i++) begin
      c[i+1] = g[i];
      run_p  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (run_p & g[j]);
        run_p  = run_p & p[j];
      end
      c[i+1] = c[i+1] | (run_p & C_in);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SLICE_W; gi++) begin : g_sum
      assign S_out[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  assign C_out   = c[SLICE_W];
  assign AND_out = g;
  assign OR_out  = A_in | B_in;
  assign XOR_out = p;

endmodule

// File: rtl/byte_serial_alu_sequencer.sv
// Multi-cycle ALU that runs a W-bit ADD/SUB/AND/OR/XOR through a single
// byte slice, least significant byte first, chaining the carry in a register.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : request/result interface (slave modport)
// out_valid rises NUM_BYTES cycles after a request is accepted and the
// result/flags are held until out_ready.
module byte_serial_alu_sequencer
  import alu_pkg::*;
#(
  parameter int NUM_BYTES = 4
)(
  input  logic                        clk,
  input  logic                        rst,
  byte_serial_alu_sequencer_if.slave  bus
);

  localparam int W     = SLICE_W * NUM_BYTES;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  state_e             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               carry_reg;
  logic [2:0]         op_reg;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;     // already inverted for SUB
  logic [W-1:0]       r_reg;
  logic               c_flag_reg;
  logic               v_flag_reg;
  logic               z_flag_reg;
  logic               n_flag_reg;
  logic               out_valid_reg;

  logic [SLICE_W-1:0] a_bytes [NUM_BYTES];
  logic [SLICE_W-1:0] b_bytes [NUM_BYTES];
  logic [SLICE_W-1:0] sum_byte, and_byte, or_byte, xor_byte, res_byte;
  logic               slice_c;
  logic [W-1:0]       r_next;    // r_reg with the current byte merged in
  logic               is_logic;
  logic               last_byte;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
      assign a_bytes[gi] = a_reg[gi*SLICE_W +: SLICE_W];
      assign b_bytes[gi] = b_reg[gi*SLICE_W +: SLICE_W];
      assign r_next[gi*SLICE_W +: SLICE_W] =
        (idx_reg == IDX_W'(gi)) ? res_byte : r_reg[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  bit8_look_ahead_carry_adder u_slice (
    .A_in    (a_bytes[idx_reg]),
    .B_in    (b_bytes[idx_reg]),
    .C_in    (carry_reg),
    .S_out   (sum_byte),
    .C_out   (slice_c),
    .AND_out (and_byte),
    .OR_out  (or_byte),
    .XOR_out (xor_byte)
  );

  assign is_logic  = (op_reg == OP_AND) || (op_reg == OP_OR) || (op_reg == OP_XOR);
  assign last_byte = (idx_reg == IDX_W'(NUM_BYTES - 1));

  // Reserved opcodes fall through to the adder result.
  always_comb begin
    res_byte = sum_byte;
    case (op_reg)
      OP_AND:  res_byte = and_byte;
      OP_OR:   res_byte = or_byte;
      OP_XOR:  res_byte = xor_byte;
      default: res_byte = sum_byte;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      op_reg        <= 3'd0;
      a_reg         <= '0;
      b_reg         <= '0;
      r_reg         <= '0;
      c_flag_reg    <= 1'b0;
      v_flag_reg    <= 1'b0;
      z_flag_reg    <= 1'b0;
      n_flag_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.A_in;
            op_reg    <= bus.op_in;
            // SUB is A + ~B + 1: invert B here, inject the +1 as carry-in.
            b_reg     <= (bus.op_in == OP_SUB) ? ~bus.B_in : bus.B_in;
            carry_reg <= (bus.op_in == OP_SUB);
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          r_reg     <= r_next;
          carry_reg <= slice_c;
          idx_reg   <= idx_reg + 1'b1;
          if (last_byte) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            c_flag_reg    <= is_logic ? 1'b0 : slice_c;
            v_flag_reg    <= is_logic ? 1'b0 :
                             ((a_reg[W-1] == b_reg[W-1]) && (r_next[W-1] != a_reg[W-1]));
            z_flag_reg    <= (r_next == '0);
            n_flag_reg    <= r_next[W-1];
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE) && !rst;
  assign bus.busy_out  = (state_reg != IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.R_out     = r_reg;
  assign bus.C_out     = c_flag_reg;
  assign bus.V_out     = v_flag_reg;
  assign bus.Z_out     = z_flag_reg;
  assign bus.N_out     = n_flag_reg;

endmodule

// File: tb/tb_byte_serial_alu_sequencer.sv
// Self-checking bench for byte_serial_alu_sequencer (NUM_BYTES = 4).
// A transaction-level reference model tracks what the outputs must be and a
// compare process checks them every falling edge; directed vectors pin both
// the DUT and the model to hand-computed values.
module tb_byte_serial_alu_sequencer;
  import alu_pkg::*;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  byte_serial_alu_sequencer_if #(.NUM_BYTES(NB)) ifc ();

  byte_serial_alu_sequencer #(.NUM_BYTES(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {V, C, R} from plain arithmetic.
  function automatic logic [33:0] model_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [32:0] s;
    logic        v;
    s = '0;
    v = 1'b0;
    case (op)
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      OP_AND: s = {1'b0, a & b};
      OP_OR:  s = {1'b0, a | b};
      OP_XOR: s = {1'b0, a ^ b};
      default: begin
        s = {1'b0, a} + {1'b0, b};
        v = (a[31] == b[31]) && (s[31] != a[31]);
      end
    endcase
    return {v, s};
  endfunction

  // ---------------- transaction-level model ----------------
  logic        m_idle, m_valid, m_known;
  int          m_cnt;
  logic [33:0] m_pend;
  logic [31:0] m_r;
  logic        m_c, m_v, m_z, m_n;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_known <= 1'b1;
      m_cnt   <= 0;
      m_r     <= '0;
      m_c     <= 1'b0;
      m_v     <= 1'b0;
      m_z     <= 1'b0;
      m_n     <= 1'b0;
    end else if (m_idle) begin
      if (ifc.in_valid) begin
        m_pend  <= model_fn(ifc.op_in, ifc.A_in, ifc.B_in);
        m_idle  <= 1'b0;
        m_known <= 1'b0;
        m_cnt   <= 1;
      end
    end else if (!m_valid) begin
      if (m_cnt == NB) begin
        m_valid <= 1'b1;
        m_known <= 1'b1;
        m_r     <= m_pend[31:0];
        m_c     <= m_pend[32];
        m_v     <= m_pend[33];
        m_z     <= (m_pend[31:0] == 32'd0);
        m_n     <= m_pend[31];
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (ifc.out_ready) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check1("in_ready", ifc.in_ready, m_idle && !rst);
      check1("out_valid", ifc.out_valid, m_valid);
      check1("busy_out", ifc.busy_out, !m_idle);
      if (m_known) begin
        check32("R_out", ifc.R_out, m_r);
        check1("C_out", ifc.C_out, m_c);
        check1("V_out", ifc.V_out, m_v);
        check1("Z_out", ifc.Z_out, m_z);
        check1("N_out", ifc.N_out, m_n);
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c, v, z, n;
  } vec_t;

  vec_t vecs [9];

  // Issues one request, jams junk requests while busy, holds the result
  // for 'hold' cycles, then accepts it. Returns edges from accept to out_valid.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output int lat);
    int  n;
    bit  ok;
    @(negedge clk);
    n = 0;
    while (!ifc.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) check1("in_ready_wait", ifc.in_ready, 1'b1);
    ifc.in_valid = 1'b1;
    ifc.op_in    = op;
    ifc.A_in     = a;
    ifc.B_in     = b;
    @(posedge clk);
    #1;
    lat = 0;
    ok  = 1'b0;
    while (lat < 20) begin
      ifc.in_valid = 1'($urandom_range(0, 1));
      ifc.op_in    = 3'($urandom_range(0, 7));
      ifc.A_in     = $urandom;
      ifc.B_in     = $urandom;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ifc.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    ifc.in_valid = 1'b0;
    if (!ok) check1("out_valid_timeout", ifc.out_valid, 1'b1);
    repeat (hold) @(negedge clk);
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int          lat;
    logic [33:0] m;
    do_op(v.op, v.a, v.b, 3, lat);
    check32("latency", 32'(lat), 32'd4);
    check32("lit_R", ifc.R_out, v.r);
    check1("lit_C", ifc.C_out, v.c);
    check1("lit_V", ifc.V_out, v.v);
    check1("lit_Z", ifc.Z_out, v.z);
    check1("lit_N", ifc.N_out, v.n);
    m = model_fn(v.op, v.a, v.b);
    check32("model_R", m[31:0], v.r);
    check1("model_C", m[32], v.c);
    check1("model_V", m[33], v.v);
    @(negedge clk);
    check1("in_ready_after_accept", ifc.in_ready, 1'b1);
    $display("directed op=%0d a=%h b=%h r=%h c=%b v=%b z=%b n=%b lat=%0d",
             v.op, v.a, v.b, ifc.R_out, ifc.C_out, ifc.V_out, ifc.Z_out, ifc.N_out, lat);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          lat;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{op: OP_ADD, a: 32'h0000_0094, b: 32'h0000_0035, r: 32'h0000_00C9, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0};
    vecs[1] = '{op: OP_ADD, a: 32'h0000_00FF, b: 32'h0000_0001, r: 32'h0000_0100, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0};
    vecs[2] = '{op: OP_ADD, a: 32'hFFFF_FFFF, b: 32'h0000_0001, r: 32'h0000_0000, c: 1'b1, v: 1'b0, z: 1'b1, n: 1'b0};
    vecs[3] = '{op: OP_SUB, a: 32'h0000_0005, b: 32'h0000_0007, r: 32'hFFFF_FFFE, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b1};
    vecs[4] = '{op: OP_ADD, a: 32'h7FFF_FFFF, b: 32'h0000_0001, r: 32'h8000_0000, c: 1'b0, v: 1'b1, z: 1'b0, n: 1'b1};
    vecs[5] = '{op: OP_SUB, a: 32'h8000_0000, b: 32'h0000_0001, r: 32'h7FFF_FFFF, c: 1'b1, v: 1'b1, z: 1'b0, n: 1'b0};
    vecs[6] = '{op: OP_AND, a: 32'h9494_3535, b: 32'h3535_9494, r: 32'h1414_1414, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0};
    vecs[7] = '{op: OP_OR,  a: 32'h9494_3535, b: 32'h3535_9494, r: 32'hB5B5_B5B5, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b1};
    vecs[8] = '{op: OP_XOR, a: 32'h9494_3535, b: 32'h3535_9494, r: 32'hA1A1_A1A1, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b1};

    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.op_in     = 3'd0;
    ifc.A_in      = '0;
    ifc.B_in      = '0;
    ifc.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check32("rst_R", ifc.R_out, 32'd0);
    check1("rst_out_valid", ifc.out_valid, 1'b0);
    check1("rst_busy", ifc.busy_out, 1'b0);
    check1("rst_in_ready", ifc.in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("idle_in_ready", ifc.in_ready, 1'b1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset during the second RUN cycle of a carry-heavy ADD.
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.op_in    = OP_ADD;
    ifc.A_in     = 32'hFFFF_FFFF;
    ifc.B_in     = 32'h0000_0001;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check1("midrun_rst_out_valid", ifc.out_valid, 1'b0);
    check32("midrun_rst_R", ifc.R_out, 32'd0);
    check1("midrun_rst_busy", ifc.busy_out, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    $display("reset mid-run applied");
    run_vec(vecs[0]);

    // Randomized traffic, including reserved opcodes and corner operands.
    for (int t = 0; t < 60; t++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      do_op(rop, ra, rb, $urandom_range(0, 3), lat);
      check32("rand_latency", 32'(lat), 32'd4);
      $display("random op=%0d a=%h b=%h r=%h c=%b v=%b z=%b n=%b",
               rop, ra, rb, ifc.R_out, ifc.C_out, ifc.V_out, ifc.Z_out, ifc.N_out);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
